// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and the APB address map used by the requester arbiter.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [31:0] APB_BASE       = 32'h1000_0000;
  localparam int          APB_NUM_SLV    = 10;
  localparam int          APB_SLOT_SHIFT = 12;

  // One 4 KiB slot per slave directly above APB_BASE; anything else never answers.
  function automatic logic addr_mapped(input logic [31:0] addr);
    logic [3:0] slot;
    slot = addr[APB_SLOT_SHIFT +: 4];
    return (addr[31:16] == APB_BASE[31:16]) && (slot < 4'(APB_NUM_SLV));
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Requester-side and master-side signals of the APB request arbiter.
interface apb_req_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
);
  // Requests: req_valid[i] is held with addr/wdata/write stable until the one-cycle
  // req_ready[i] pulse; rsp_valid[i] is a one-cycle completion pulse, no back-pressure.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_addr;
  logic [NUM_REQ-1:0][31:0] req_wdata;
  logic [NUM_REQ-1:0]       req_write;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [31:0]              rsp_rdata;
  logic                     rsp_err;
  logic                     m_transfer;
  logic [31:0]              m_addr;
  logic [31:0]              m_wdata;
  logic                     m_write;
  logic                     m_ready;
  logic [31:0]              m_rdata;
  logic                     busy;
  logic [IDX_W-1:0]         grant_idx;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_write, m_ready, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_transfer, m_addr, m_wdata, m_write, busy, grant_idx
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_write, m_ready, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_transfer, m_addr, m_wdata, m_write, busy, grant_idx
  );
endinterface

// File: rtl/apb_req_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after the pointer, wrapping.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx,
  output logic          o_any
);

  always_comb begin : p_pick
    int idx;
    idx       = 0;
    o_gnt     = '0;
    o_gnt_idx = '0;
    o_any     = 1'b0;
    // k runs 1..N so the pointer position itself has the lowest priority.
    for (int k = 1; k <= N; k++) begin
      idx = int'(i_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!o_any && i_req[IW'(idx)]) begin
        o_any              = 1'b1;
        o_gnt[IW'(idx)]    = 1'b1;
        o_gnt_idx          = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin share of one APB master port among NUM_REQ requesters, one transaction
// in flight, unmapped addresses answered locally with an error.
module apb_req_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  apb_req_arbiter_if.slave bus,
  output arb_state_e       o_dbg_state
);

  arb_state_e         r_state;
  arb_state_e         w_state_nx;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_any;
  logic               w_accept;
  logic               w_mapped;
  logic [31:0]        w_sel_addr;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic               r_write;
  logic               r_err;

  rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );

  assign w_accept   = (r_state == IDLE) && w_any;
  assign w_sel_addr = bus.req_addr[w_gnt_idx];
  assign w_mapped   = addr_mapped(w_sel_addr);

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (w_any) w_state_nx = w_mapped ? ISSUE : RESP;
      ISSUE:   w_state_nx = WAIT;
      WAIT:    if (bus.m_ready) w_state_nx = RESP;
      RESP:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_ptr   <= IDX_W'(NUM_REQ - 1);
      r_idx   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nx;
      // Master-facing fields only change on accept, so they stay quiet while idle.
      if (w_accept) begin
        r_ptr   <= w_gnt_idx;
        r_idx   <= w_gnt_idx;
        r_addr  <= w_sel_addr;
        r_wdata <= bus.req_wdata[w_gnt_idx];
        r_write <= bus.req_write[w_gnt_idx];
        r_err   <= !w_mapped;
        r_rdata <= '0;
      end
      if ((r_state == WAIT) && bus.m_ready && !r_write) begin
        r_rdata <= bus.m_rdata;
      end
    end
  end

  // req_ready is combinational from req_valid, so it is also forced low during reset.
  assign bus.req_ready  = (w_accept && PRESETn) ? w_gnt : '0;
  assign bus.rsp_valid  = (r_state == RESP) ? (NUM_REQ'(1) << r_idx) : '0;
  assign bus.rsp_rdata  = (r_state == RESP) ? r_rdata : '0;
  assign bus.rsp_err    = (r_state == RESP) && r_err;
  assign bus.m_transfer = (r_state == ISSUE);
  assign bus.m_addr     = r_addr;
  assign bus.m_wdata    = r_wdata;
  assign bus.m_write    = r_write;
  assign bus.busy       = (r_state != IDLE);
  assign bus.grant_idx  = r_idx;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Directed bench for apb_req_arbiter with a cycle-level APB master/slave model.
module tb_apb_req_arbiter;
  import apb_arb_pkg::*;

  localparam int NR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  arb_state_e dbg_state;

  apb_req_arbiter_if #(.NUM_REQ(NR)) bus ();

  apb_req_arbiter #(.NUM_REQ(NR)) dut (
    .PCLK        (clk),
    .PRESETn     (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          ready_at = -1;
  int          slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  int          xfer_cnt = 0;
  logic [31:0] cap_addr = '0;
  logic [31:0] cap_wdata = '0;
  logic        cap_write = 1'b0;

  typedef struct {
    int          r;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int          wt;
    logic [31:0] srd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_xfer;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", name, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave side: m_ready one cycle after SETUP plus slv_wait wait states.
  initial begin
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = rst_n && (cyc == ready_at);
      bus.m_rdata = (rst_n && (cyc == ready_at)) ? slv_rdata : 32'h0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      ready_at = -1;
    end else if (bus.m_transfer) begin
      chk("no_overlap", 32'(ready_at >= cyc), 32'h0);
      ready_at  = cyc + 2 + slv_wait;
      xfer_cnt  = xfer_cnt + 1;
      cap_addr  = bus.m_addr;
      cap_wdata = bus.m_wdata;
      cap_write = bus.m_write;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'h0);
    chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'h0);
    chk({tag, "_m_transfer"}, 32'(bus.m_transfer), 32'h0);
    chk({tag, "_m_addr"}, bus.m_addr, 32'h0);
    chk({tag, "_m_wdata"}, bus.m_wdata, 32'h0);
    chk({tag, "_m_write"}, 32'(bus.m_write), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_grant_idx"}, 32'(bus.grant_idx), 32'h0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (!bus.busy) break;
    end
    chk({tag, "_drain"}, 32'(bus.busy), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   t0;
    int   lat;
    int   x0;
    logic found;
    @(posedge clk);
    #1;
    slv_wait  = v.wt;
    slv_rdata = v.srd;
    x0        = xfer_cnt;
    bus.req_addr[v.r]  = v.addr;
    bus.req_wdata[v.r] = v.wdata;
    bus.req_write[v.r] = v.wr;
    bus.req_valid[v.r] = 1'b1;
    @(negedge clk);
    t0 = cyc;
    chk({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << v.r));
    chk({tag, "_busy_t0"}, 32'(bus.busy), 32'h0);
    @(posedge clk);
    #1;
    bus.req_valid[v.r] = 1'b0;
    found = 1'b0;
    lat   = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin
        found = 1'b1;
        lat   = cyc - t0;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << v.r));
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, v.exp_rd);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
        chk({tag, "_grant_idx"}, 32'(bus.grant_idx), 32'(v.r));
      end
    end
    chk({tag, "_rsp_seen"}, 32'(found), 32'h1);
    chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, "_xfers"}, 32'(xfer_cnt - x0), 32'(v.exp_xfer));
    if (v.exp_xfer == 1) begin
      chk({tag, "_m_addr"}, cap_addr, v.addr);
      chk({tag, "_m_wdata"}, cap_wdata, v.wdata);
      chk({tag, "_m_write"}, 32'(cap_write), 32'(v.wr));
    end
  endtask

  task automatic run_pair(input int exp_idx, input string tag);
    @(posedge clk);
    #1;
    slv_wait = 0;
    for (int i = 0; i < 2; i++) begin
      bus.req_addr[i]  = 32'h1000_1000;
      bus.req_wdata[i] = 32'(i);
      bus.req_write[i] = 1'b1;
    end
    bus.req_valid = 3'b011;
    @(negedge clk);
    chk({tag, "_winner"}, 32'(bus.req_ready), 32'(1 << exp_idx));
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    wait_idle(tag);
  endtask

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_write = '0;

    //              r  addr           wdata          wr  wt srd            exp_rd         err lat xfer
    vecs[0] = '{0, 32'h1000_0004, 32'hDEAD_BEEF, 1'b1, 0, 32'hAAAA_5555, 32'h0,        1'b0, 4, 1};
    vecs[1] = '{1, 32'h1000_2008, 32'h0,         1'b0, 2, 32'h1234_5678, 32'h1234_5678, 1'b0, 6, 1};
    vecs[2] = '{2, 32'h2000_0000, 32'h0,         1'b0, 0, 32'h5555_AAAA, 32'h0,        1'b1, 1, 0};
    vecs[3] = '{2, 32'h1000_9FFC, 32'h0,         1'b0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 5, 1};
    vecs[4] = '{1, 32'h1000_A000, 32'h0BAD_0BAD, 1'b1, 0, 32'h1111_2222, 32'h0,        1'b1, 1, 0};
    vecs[5] = '{0, 32'h1000_0000, 32'h0,         1'b0, 0, 32'h0000_0001, 32'h0000_0001, 1'b0, 4, 1};
    vecs[6] = '{1, 32'h0FFF_FFFC, 32'h0,         1'b0, 0, 32'h7777_7777, 32'h0,        1'b1, 1, 0};

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while the master waits on a slow slave: drop everything, then recover.
    @(posedge clk);
    #1;
    slv_wait          = 5;
    slv_rdata         = 32'h9999_9999;
    bus.req_addr[0]   = 32'h1000_3000;
    bus.req_write[0]  = 1'b0;
    bus.req_valid[0]  = 1'b1;
    @(negedge clk);
    chk("t5_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_in_wait", 32'(dbg_state), 32'(WAIT));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    repeat (2) @(negedge clk);
    chk("t5_no_rsp", 32'(bus.rsp_valid), 32'h0);
    #2;
    rst_n = 1'b1;
    run_vec(vecs[5], "t5_after");

    // Fresh pointer, all three requesters held: rotation 0,1,2,0,1,2.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t3_reset");
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    slv_wait = 0;
    for (int i = 0; i < NR; i++) begin
      bus.req_addr[i]  = 32'h1000_0000 + 32'(i << 12);
      bus.req_wdata[i] = 32'hA000_0000 + 32'(i);
      bus.req_write[i] = 1'b1;
    end
    bus.req_valid = 3'b111;
    n = 0;
    for (int c = 0; c < 80 && n < 6; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        chk($sformatf("t3_order%0d", n), 32'(bus.req_ready), 32'(1 << (n % 3)));
        n++;
        if (n == 6) begin
          @(posedge clk);
          #1;
          bus.req_valid = '0;
        end
      end
    end
    chk("t3_count", 32'(n), 32'd6);
    wait_idle("t3");

    // Pointer-dependent priority between req0 and req1.
    run_vec(vecs[5], "t6_req0");
    run_vec(vecs[1], "t6_req1");
    run_pair(0, "t6_pair_ptr1");
    run_pair(1, "t6_pair_ptr0");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
